// File: rtl/mips_dmem_io.sv
// Data-side memory/MMIO responder for the single-cycle MIPS core: word RAM, LED register,
// optional timer (define MIPS_DMEM_TIMER_EN) and a FIFO-fed byte-serial TX port.
module mips_dmem_io #(
    parameter int RAM_AW       = 6,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  leds,
    output logic        tx,
    output logic        irq
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST     = BW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   FIFO_FULL_CNT = (PW+1)'(FIFO_DEPTH);

    localparam logic [5:0] OFF_LED  = 6'h00;
    localparam logic [5:0] OFF_TCNT = 6'h01;
    localparam logic [5:0] OFF_TCMP = 6'h02;
    localparam logic [5:0] OFF_STAT = 6'h03;
    localparam logic [5:0] OFF_TXD  = 6'h04;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

    logic              w_mmio;
    logic [5:0]        w_off;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_mmio_we;
    logic              w_ram_we;
    logic              w_unused;

    // MMIO offsets are word-granular, so address[1:0] never takes part in decode.
    assign w_mmio    = (address[31:16] == 16'hFFFF);
    assign w_off     = address[7:2];
    assign w_ram_idx = address[RAM_AW+1:2];
    assign w_mmio_we = memwrite & w_mmio;
    assign w_ram_we  = memwrite & ~w_mmio;
    assign w_unused  = ^{address[15:8], address[1:0]};

    logic [31:0] r_ram [0:(1<<RAM_AW)-1];

    always_ff @(posedge clk) begin
        if (w_ram_we) r_ram[w_ram_idx] <= writedata;
    end

    logic [7:0] r_leds;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_leds <= '0;
        else if (w_mmio_we && w_off == OFF_LED) r_leds <= writedata[7:0];
    end

    assign leds = r_leds;

    logic [31:0] w_tcnt;
    logic [31:0] w_tcmp;
    logic        w_match;

`ifdef MIPS_DMEM_TIMER_EN
    logic [31:0] r_tcnt;
    logic [31:0] r_tcmp;
    logic        r_match;
    logic        w_hit;
    logic        w_clr;

    assign w_hit = (r_tcnt == r_tcmp);
    assign w_clr = w_mmio_we && (w_off == OFF_STAT) && writedata[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tcnt  <= '0;
            r_tcmp  <= '1;
            r_match <= 1'b0;
        end else begin
            r_tcnt <= (w_mmio_we && w_off == OFF_TCNT) ? 32'd0 : r_tcnt + 32'd1;
            if (w_mmio_we && w_off == OFF_TCMP) r_tcmp <= writedata;
            // A fresh match beats a same-cycle clear so no event is lost.
            r_match <= w_hit | (r_match & ~w_clr);
        end
    end

    assign w_tcnt  = r_tcnt;
    assign w_tcmp  = r_tcmp;
    assign w_match = r_match;
`else
    assign w_tcnt  = '0;
    assign w_tcmp  = '0;
    assign w_match = 1'b0;
`endif

    assign irq = w_match;

    tx_state_t     r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;

    logic [7:0]    r_fifo [0:FIFO_DEPTH-1];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic [7:0]    w_head;
    logic          w_busy;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FIFO_FULL_CNT);
    assign w_head  = r_fifo[r_rd_ptr];
    assign w_busy  = (r_state != S_IDLE);
    assign w_pop   = ~w_empty & ((r_state == S_IDLE) |
                                 ((r_state == S_STOP) && (r_baud == BAUD_LAST)));
    // A push into a full FIFO is accepted only when a pop frees a slot that same cycle.
    assign w_push  = w_mmio_we && (w_off == OFF_TXD) && (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= writedata[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_START;
                        r_shift <= w_head;
                        r_baud  <= '0;
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_DATA: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_STOP: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud <= '0;
                        // Chain straight into the next start bit when more bytes wait.
                        if (w_pop) begin
                            r_state <= S_START;
                            r_shift <= w_head;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign tx = r_tx;

    always_comb begin
        readdata = '0;
        if (w_mmio) begin
            case (w_off)
                OFF_LED:  readdata = {24'd0, r_leds};
                OFF_TCNT: readdata = w_tcnt;
                OFF_TCMP: readdata = w_tcmp;
                OFF_STAT: readdata = {28'd0, w_empty, w_full, w_busy, w_match};
                default:  readdata = '0;
            endcase
        end else begin
            readdata = r_ram[w_ram_idx];
        end
    end

endmodule

// File: tb/tb_mips_dmem_io.sv
// Directed self-checking bench for mips_dmem_io: RAM, LED, timer, serial TX and reset behaviour.
module tb_mips_dmem_io;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  leds;
    logic        tx;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

`ifdef MIPS_DMEM_TIMER_EN
    localparam logic [31:0] EXP_TCMP_RST = 32'hFFFF_FFFF;
    localparam logic [31:0] EXP_TCMP_5   = 32'd5;
    localparam logic [31:0] EXP_IRQ      = 32'd1;
`else
    localparam logic [31:0] EXP_TCMP_RST = 32'd0;
    localparam logic [31:0] EXP_TCMP_5   = 32'd0;
    localparam logic [31:0] EXP_IRQ      = 32'd0;
`endif

    localparam logic [31:0] A_LED  = 32'hFFFF_0000;
    localparam logic [31:0] A_TCNT = 32'hFFFF_0004;
    localparam logic [31:0] A_TCMP = 32'hFFFF_0008;
    localparam logic [31:0] A_STAT = 32'hFFFF_000C;
    localparam logic [31:0] A_TXD  = 32'hFFFF_0010;

    mips_dmem_io #(.RAM_AW(6), .CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .address   (address),
        .writedata (writedata),
        .readdata  (readdata),
        .leds      (leds),
        .tx        (tx),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        address   = a;
        writedata = d;
        step();
        memwrite  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    // Serial frame level for bit slot k: 0 start, 1..8 data LSB first, 9 stop.
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    logic [7:0] burst [6];
    int t;

    initial begin
        burst = '{8'h01, 8'h80, 8'hC3, 8'h5A, 8'hFF, 8'h00};
        reset = 1'b0; memwrite = 1'b0; address = '0; writedata = '0;
        repeat (3) step();

        chk("rst_leds", {24'd0, leds}, 32'd0);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        rd("rst_tcnt", A_TCNT, 32'd0);
        rd("rst_stat", A_STAT, 32'h8);
        rd("rst_tcmp", A_TCMP, EXP_TCMP_RST);
        reset = 1'b1;
        step();

        // RAM write/read, aliasing and ignored byte offset
        wr(32'h0000_0008, 32'hDEAD_BEEF);
        wr(32'h0000_000C, 32'h1234_5678);
        rd("ram_rd", 32'h0000_0008, 32'hDEAD_BEEF);
        rd("ram_alias", 32'h0000_0108, 32'hDEAD_BEEF);
        rd("ram_lsb_ign", 32'h0000_000B, 32'hDEAD_BEEF);
        step();
        rd("ram_rd2", 32'h0000_010C, 32'h1234_5678);

        // LED register and asynchronous reset
        wr(A_LED, 32'h0000_01A5);
        chk("led_out", {24'd0, leds}, 32'hA5);
        rd("led_rd", A_LED, 32'hA5);
        rd("led_rd_lsb", 32'hFFFF_0001, 32'hA5);
        reset = 1'b0;
        #1;
        chk("led_async_rst", {24'd0, leds}, 32'd0);
        step();
        step();
        reset = 1'b1;
        rd("ram_keep_rst", 32'h0000_0008, 32'hDEAD_BEEF);
        repeat (12) step();

        // Timer match, irq and write-1-clear including same-cycle set
        wr(A_TCMP, 32'd5);
        wr(A_TCNT, 32'h1234);
        rd("tcnt_clr", A_TCNT, 32'd0);
        rd("tcmp_rd", A_TCMP, EXP_TCMP_5);
        repeat (5) begin
            step();
            chk("irq_early", 32'(irq), 32'd0);
        end
        step();
        chk("irq_match", 32'(irq), EXP_IRQ);
        rd("stat_match", A_STAT, {28'd0, 4'h8} | EXP_IRQ);
        wr(A_STAT, 32'd1);
        chk("irq_cleared", 32'(irq), 32'd0);
        wr(A_TCNT, 32'd0);
        repeat (5) step();
        wr(A_STAT, 32'd1);
        chk("irq_set_wins", 32'(irq), EXP_IRQ);
        wr(A_STAT, 32'd1);
        chk("irq_cleared2", 32'(irq), 32'd0);
        step();

        // Single frame 0x55
        wr(A_TXD, 32'h55);
        chk("tx_pre_start", 32'(tx), 32'd1);
        address = A_STAT;
        step();
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < 16; c++) begin
                chk("tx55_bit", 32'(tx), 32'(exp_bit(8'h55, k)));
                chk("tx55_busy", 32'(readdata[1]), 32'd1);
                step();
            end
        end
        chk("tx55_idle", 32'(tx), 32'd1);
        rd("tx55_stat", A_STAT, 32'h8);
        step();

        // Burst of six: five sent back to back, sixth dropped
        for (int i = 0; i < 5; i++) wr(A_TXD, {24'd0, burst[i]});
        rd("fifo_full", A_STAT, 32'h6);
        wr(A_TXD, {24'd0, burst[5]});
        rd("fifo_full_drop", A_STAT, 32'h6);
        for (t = 4; t < 800; t++) begin
            chk("burst_bit", 32'(tx), 32'(exp_bit(burst[t / 160], (t % 160) / 16)));
            step();
        end
        chk("burst_end_tx", 32'(tx), 32'd1);
        rd("burst_end_stat", A_STAT, 32'h8);
        for (int i = 0; i < 40; i++) begin
            step();
            if (i % 8 == 0) chk("burst_no_6th", 32'(tx), 32'd1);
        end

        // Reset during data bit 3 drops the frame and the queue
        wr(A_TXD, 32'hA5);
        wr(A_TXD, 32'h3C);
        wr(A_TXD, 32'h0F);
        repeat (69) step();
        chk("mid_bit3", 32'(tx), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(tx), 32'd1);
        step();
        reset = 1'b1;
        step();
        rd("mid_rst_stat", A_STAT, 32'h8);
        rd("unmapped", 32'hFFFF_0020, 32'd0);
        rd("txd_rd", A_TXD, 32'd0);
        for (int i = 0; i < 200; i++) begin
            step();
            if (i % 20 == 0) chk("mid_rst_quiet", 32'(tx), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
